apu_envelope_length: RTL and testbench
======================================

Name: apu_envelope_length

Overview:
Per-channel consumer of the APU frame-sequencer clock enables. It accepts the quarter-frame and half-frame enables, plus the channel's register writes, and maintains the channel's envelope generator and length counter. It produces the 4-bit channel volume and a length-active flag. It is instantiated once per pulse/noise channel, between the frame counter and the channel's mixer input.

Parameters:
HALT_BIT, 5, bit position of the length-halt/envelope-loop flag in the offset-0 register write
ENV_EN, 1, 1 = envelope generator present; 0 = volume output tied to 0 (length counter only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
cpu_clk_en  input  1  CPU-cycle strobe; all tick inputs are qualified by it
quarter_clk_en  input  1  quarter-frame tick from the frame sequencer
half_clk_en  input  1  half-frame tick from the frame sequencer
channel_en  input  1  channel enable bit from the status register
reg_wr_en  input  1  register write strobe, one clk wide
reg_addr  input  2  channel-local register offset (0..3)
reg_wr_data  input  8  register write data
volume  output  4  envelope or constant volume
length_nonzero  output  1  high while length counter != 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: all state clears to 0: halt, const_vol, vol_param[3:0], start, divider[3:0], decay[3:0], length[7:0]. Outputs reset to volume=0 and length_nonzero=0.
- Tick qualification: q_tick = quarter_clk_en & cpu_clk_en; h_tick = half_clk_en & cpu_clk_en. The frame enables can stay high for several clk cycles within one CPU cycle; only the qualified tick acts, so each event fires exactly once.
- Offset-0 write: halt <= data[HALT_BIT]; const_vol <= data[4]; vol_param <= data[3:0].
- Offset-3 write:
  - If channel_en=1: length <= LEN_TABLE[data[7:3]].
  - Independent of channel_en: start <= 1.
- Offsets 1 and 2: ignored.
- LEN_TABLE (index 0..31): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Envelope, on q_tick (only when ENV_EN=1):
  - start=1: start<=0, decay<=15, divider<=vol_param.
  - start=0 and divider==0: divider<=vol_param, then:
    - decay>0: decay--
    - decay==0 and halt=1: decay<=15 (loop)
    - otherwise decay holds at 0.
  - start=0 and divider!=0: divider--.
- Length counter, on h_tick: if length!=0 and halt=0, length--. Length never wraps below 0.
- channel_en=0: length forced to 0 every cycle. This overrides the offset-3 load and h_tick.
- Simultaneous events:
  - Offset-3 write in the same cycle as h_tick: the load wins and no decrement is applied.
  - Offset-3 write in the same cycle as q_tick: the q_tick processes the old start value; start is 1 after the edge.
  - Offset-0 write in the same cycle as a tick: the tick uses the old register values.
- Outputs:
  - volume = ENV_EN ? (const_vol ? vol_param : decay) : 0.
  - length_nonzero = (length != 0).
  - Both are combinational from registered state, so they are visible the clk cycle after the causing edge.
  - volume is not gated by length here; gating is the mixer's job.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Pending start and divider state are lost.

Test Plan:
- Reset: assert rst with random inputs toggling -> volume=0, length_nonzero=0 throughout reset and on the first cycle after release.
- Length countdown:
  - Setup: channel_en=1; write off0=0x00, then off3=0x08 (index 1).
  - Apply h_ticks -> length_nonzero stays high through 253 h_ticks and drops the cycle after the 254th.
  - A quarter/half enable held high for 4 clk with a single cpu_clk_en -> exactly one decrement.
- Envelope decay:
  - off0=0x03, then write off3 -> the first q_tick gives volume=15.
  - Volume then decrements every 4 q_ticks and reaches 0 at q_tick 61, holding 0 after that.
  - Repeat with off0=0x23 (loop) -> volume=15 again at q_tick 65.
- Constant volume and halt:
  - off0=0x3A -> volume=10 regardless of q_ticks.
  - After off3=0x18 (length 2) plus 10 h_ticks -> length_nonzero remains 1.
- Channel disable:
  - Clear channel_en mid-count -> length_nonzero=0 the next cycle.
  - Off3 write while disabled -> length stays 0, but envelope start still restarts decay at 15.
- Collisions:
  - Off3=0x08 written in the same cycle as h_tick -> length=254 (not 253).
  - Off3 write coincident with q_tick while start=0 -> decay follows the old divider path; the next q_tick sets volume=15.

Source files
------------

// File: rtl/apu_envelope_length_if.sv
// Bundle between the frame sequencer / register bus and one channel's envelope + length unit.
// master drives ticks and register writes; slave returns volume and length status.
interface apu_envelope_length_if;
  logic       cpu_clk_en;
  logic       quarter_clk_en;
  logic       half_clk_en;
  logic       channel_en;
  logic       reg_wr_en;
  logic [1:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic [3:0] volume;
  logic       length_nonzero;

  modport master (
    output cpu_clk_en, quarter_clk_en, half_clk_en, channel_en,
    output reg_wr_en, reg_addr, reg_wr_data,
    input  volume, length_nonzero
  );

  modport slave (
    input  cpu_clk_en, quarter_clk_en, half_clk_en, channel_en,
    input  reg_wr_en, reg_addr, reg_wr_data,
    output volume, length_nonzero
  );
endinterface

// File: rtl/apu_envelope_length.sv
// Per-channel envelope generator and length counter driven by frame-sequencer ticks.
// Outputs are combinational from state (visible one clk after the causing edge); no backpressure.
module apu_envelope_length #(
  parameter int HALT_BIT = 5,
  parameter bit ENV_EN   = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  apu_envelope_length_if.slave bus
);

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  logic       q_tick;
  logic       h_tick;
  logic       wr0;
  logic       wr3;
  logic       halt;
  logic       const_vol;
  logic       start;
  logic [3:0] vol_param;
  logic [3:0] divider;
  logic [3:0] decay;
  logic [7:0] length;

  // Frame enables may span several clk within one CPU cycle; only the qualified tick acts.
  assign q_tick = bus.quarter_clk_en & bus.cpu_clk_en;
  assign h_tick = bus.half_clk_en & bus.cpu_clk_en;
  assign wr0    = bus.reg_wr_en && (bus.reg_addr == 2'd0);
  assign wr3    = bus.reg_wr_en && (bus.reg_addr == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt      <= 1'b0;
      const_vol <= 1'b0;
      vol_param <= 4'd0;
    end else if (wr0) begin
      halt      <= bus.reg_wr_data[HALT_BIT];
      const_vol <= bus.reg_wr_data[4];
      vol_param <= bus.reg_wr_data[3:0];
    end
  end

  // A coincident offset-3 write lets the tick see the old start, then re-arms start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start   <= 1'b0;
      divider <= 4'd0;
      decay   <= 4'd0;
    end else begin
      if (ENV_EN && q_tick) begin
        if (start) begin
          start   <= 1'b0;
          decay   <= 4'd15;
          divider <= vol_param;
        end else if (divider == 4'd0) begin
          divider <= vol_param;
          if (decay != 4'd0)
            decay <= decay - 4'd1;
          else if (halt)
            decay <= 4'd15;
        end else begin
          divider <= divider - 4'd1;
        end
      end
      if (wr3)
        start <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      length <= 8'd0;
    else if (!bus.channel_en)
      length <= 8'd0;
    else if (wr3)
      length <= LEN_TABLE[bus.reg_wr_data[7:3]];
    else if (h_tick && (length != 8'd0) && !halt)
      length <= length - 8'd1;
  end

  assign bus.volume         = ENV_EN ? (const_vol ? vol_param : decay) : 4'd0;
  assign bus.length_nonzero = (length != 8'd0);

endmodule

// File: tb/tb_apu_envelope_length.sv
// Directed vector table plus hand-written multi-cycle sequences for apu_envelope_length.
module tb_apu_envelope_length;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  apu_envelope_length_if bus ();

  apu_envelope_length #(.HALT_BIT(5), .ENV_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cpu;
    logic       q;
    logic       h;
    logic       chen;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [3:0] vol;
    logic       ln;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [3:0] ev, input logic el);
    checks++;
    if (bus.volume !== ev || bus.length_nonzero !== el) begin
      errors++;
      $display("FAIL %s: volume=%0d length_nonzero=%0b, required volume=%0d length_nonzero=%0b",
               name, bus.volume, bus.length_nonzero, ev, el);
    end
  endtask

  task automatic check_ln(input string name, input logic el);
    checks++;
    if (bus.length_nonzero !== el) begin
      errors++;
      $display("FAIL %s: length_nonzero=%0b, required %0b", name, bus.length_nonzero, el);
    end
  endtask

  task automatic check_vol(input string name, input logic [3:0] ev);
    checks++;
    if (bus.volume !== ev) begin
      errors++;
      $display("FAIL %s: volume=%0d, required %0d", name, bus.volume, ev);
    end
  endtask

  // One clk with the given strobes, then strobes return to idle; sampled 1 time unit after the edge.
  task automatic step(input logic cpu, input logic q, input logic h, input logic wr,
                      input logic [1:0] addr, input logic [7:0] data);
    bus.cpu_clk_en     = cpu;
    bus.quarter_clk_en = q;
    bus.half_clk_en    = h;
    bus.reg_wr_en      = wr;
    bus.reg_addr       = addr;
    bus.reg_wr_data    = data;
    @(posedge clk);
    #1;
    bus.cpu_clk_en     = 1'b0;
    bus.quarter_clk_en = 1'b0;
    bus.half_clk_en    = 1'b0;
    bus.reg_wr_en      = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    step(1'b0, 1'b0, 1'b0, 1'b1, addr, data);
  endtask

  // Frame enable held for 4 clk with a single cpu strobe: must act exactly once.
  task automatic held_tick(input bit quarter);
    for (int c = 0; c < 4; c++)
      step(c == 1, quarter, !quarter, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.channel_en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    vecs = '{
      '{'0, '0, '0, '1, '0, 2'd0, 8'h00, 4'd0,  '0},
      '{'0, '0, '0, '1, '1, 2'd0, 8'h3A, 4'd10, '0},
      '{'0, '0, '0, '1, '1, 2'd3, 8'h18, 4'd10, '1},
      '{'1, '0, '1, '1, '0, 2'd0, 8'h00, 4'd10, '1},
      '{'1, '1, '0, '1, '0, 2'd0, 8'h00, 4'd10, '1},
      '{'0, '0, '0, '1, '1, 2'd1, 8'hFF, 4'd10, '1},
      '{'0, '0, '0, '1, '1, 2'd2, 8'h00, 4'd10, '1},
      '{'0, '0, '0, '1, '1, 2'd0, 8'h00, 4'd15, '1},
      '{'0, '0, '1, '1, '0, 2'd0, 8'h00, 4'd15, '1},
      '{'1, '0, '1, '1, '0, 2'd0, 8'h00, 4'd15, '1},
      '{'1, '0, '1, '1, '0, 2'd0, 8'h00, 4'd15, '0},
      '{'1, '0, '1, '1, '0, 2'd0, 8'h00, 4'd15, '0},
      '{'1, '0, '1, '1, '1, 2'd3, 8'h08, 4'd15, '1},
      '{'1, '1, '0, '1, '0, 2'd0, 8'h00, 4'd15, '1},
      '{'1, '1, '0, '1, '0, 2'd0, 8'h00, 4'd14, '1},
      '{'1, '1, '0, '1, '0, 2'd0, 8'h00, 4'd13, '1},
      '{'0, '0, '0, '0, '0, 2'd0, 8'h00, 4'd13, '0},
      '{'0, '0, '0, '0, '1, 2'd3, 8'h08, 4'd13, '0},
      '{'1, '1, '0, '0, '0, 2'd0, 8'h00, 4'd15, '0},
      '{'1, '1, '0, '1, '0, 2'd0, 8'h00, 4'd14, '0}
    };

    // Reset held with random input activity.
    for (int i = 0; i < 6; i++) begin
      bus.cpu_clk_en     = 1'($urandom);
      bus.quarter_clk_en = 1'($urandom);
      bus.half_clk_en    = 1'($urandom);
      bus.channel_en     = 1'($urandom);
      bus.reg_wr_en      = 1'($urandom);
      bus.reg_addr       = 2'($urandom);
      bus.reg_wr_data    = 8'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", 4'd0, 1'b0);
    end
    bus.channel_en = 1'b0;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    check("reset_release", 4'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      bus.channel_en = vecs[i].chen;
      step(vecs[i].cpu, vecs[i].q, vecs[i].h, vecs[i].wr, vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].vol, vecs[i].ln);
    end

    // Length 254 countdown, plain load.
    bus.channel_en = 1'b1;
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h08);
    check_ln("len254_load", 1'b1);
    for (int i = 1; i <= 253; i++) begin
      held_tick(1'b0);
      check_ln("len254_hold", 1'b1);
    end
    held_tick(1'b0);
    check_ln("len254_expire", 1'b0);

    // Load coincident with h_tick: load wins, no decrement.
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'h08);
    check_ln("collide_h_load", 1'b1);
    for (int i = 1; i <= 253; i++) begin
      held_tick(1'b0);
      check_ln("collide_h_hold", 1'b1);
    end
    held_tick(1'b0);
    check_ln("collide_h_expire", 1'b0);

    wr(2'd3, 8'h18);
    held_tick(1'b0);
    check_ln("held_half_once", 1'b1);
    held_tick(1'b0);
    check_ln("held_half_second", 1'b0);

    // Envelope decay without loop: 15 at q1, -1 every 4 ticks, 0 from q61.
    wr(2'd0, 8'h03);
    wr(2'd3, 8'h00);
    for (int n = 1; n <= 70; n++) begin
      int k;
      k = (n - 1) / 4;
      held_tick(1'b1);
      check_vol($sformatf("decay_q%0d", n), (k <= 15) ? 4'(15 - k) : 4'd0);
    end

    // Looping envelope: back to 15 at q65.
    wr(2'd0, 8'h23);
    wr(2'd3, 8'h00);
    for (int n = 1; n <= 70; n++) begin
      int k;
      k = (n - 1) / 4;
      held_tick(1'b1);
      check_vol($sformatf("loop_q%0d", n), 4'(15 - (k % 16)));
    end

    // Offset-3 write coincident with q_tick while start=0 and divider=0.
    wr(2'd0, 8'h03);
    wr(2'd3, 8'h00);
    for (int n = 1; n <= 8; n++)
      held_tick(1'b1);
    check_vol("collide_q_pre", 4'd14);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'h00);
    check_vol("collide_q_oldpath", 4'd13);
    held_tick(1'b1);
    check_vol("collide_q_restart", 4'd15);

    // Constant volume with halt.
    wr(2'd0, 8'h3A);
    for (int n = 0; n < 5; n++) begin
      held_tick(1'b1);
      check_vol("const_vol", 4'd10);
    end
    wr(2'd3, 8'h18);
    for (int n = 0; n < 10; n++)
      held_tick(1'b0);
    check("halt_len", 4'd10, 1'b1);

    // Asynchronous reset mid-cycle clears immediately.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    check("post_async_reset", 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
